sigmoid_rr_scheduler: RTL and testbench

//  Shares one sigmoid core (i_in_valid/i_x -> o_out_valid/o_y, fixed latency) between NREQ requesters.

---
 rtl/sigmoid_rr_scheduler.sv | 151 +++++++++++++++
 tb/tb_sigmoid_rr_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_rr_scheduler.sv
// Round-robin front end sharing one fixed-latency sigmoid core across NREQ requesters; grant to rsp_valid is LAT+1 edges.
// A requester is not granted again until its held result has been taken, so rsp_ready stalls only that requester.
module sigmoid_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  parameter int XW   = 8,
  parameter int YW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*XW-1:0] req_x,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [NREQ*YW-1:0] rsp_y,
  output logic               core_in_valid,
  output logic [XW-1:0]      core_x,
  input  logic [YW-1:0]      core_y,
  input  logic               core_out_valid,
  output logic               busy,
  output logic               err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] idx;
  } tag_t;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] pend_q, pend_d;
  tag_t            tag_q [LAT];
  tag_t            tag_d [LAT];
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [YW-1:0]   rsp_y_q [NREQ];
  logic [YW-1:0]   rsp_y_d [NREQ];
  logic            err_q, err_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] rsp_fire;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  tag_t            head;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan from ptr upwards; rst_n is active-high, so nothing is granted while it is asserted.
  always_comb begin
    logic [IW-1:0] cand;
    elig    = req_valid & ~pend_q;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst_n) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
  end

  always_comb begin
    req_ready     = '0;
    core_x        = '0;
    core_in_valid = gnt_any;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
      core_x             = req_x[gnt_idx*XW +: XW];
    end
  end

  always_comb begin
    head        = tag_q[LAT-1];
    ptr_d       = gnt_any ? wrap_add(gnt_idx, 1) : ptr_q;
    pend_d      = pend_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    err_d       = err_q;
    rsp_fire    = rsp_valid_q & rsp_ready;

    tag_d[0].v   = gnt_any;
    tag_d[0].idx = gnt_idx;
    for (int i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    rsp_valid_d = rsp_valid_d & ~rsp_fire;
    pend_d      = pend_d & ~rsp_fire;

    // A head tag and the core's valid must coincide; either one alone is a core/pipe desync.
    if (core_out_valid && head.v) begin
      rsp_valid_d[head.idx] = 1'b1;
      rsp_y_d[head.idx]     = core_y;
    end else if (core_out_valid) begin
      err_d = 1'b1;
    end else if (head.v) begin
      err_d              = 1'b1;
      pend_d[head.idx]   = 1'b0;
    end

    if (gnt_any) begin
      pend_d[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr_q       <= '0;
      pend_q      <= '0;
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        rsp_y_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      tag_q       <= tag_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  always_comb begin
    rsp_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_y[i*YW +: YW] = rsp_y_q[i];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign busy      = |pend_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// Directed bench for sigmoid_rr_scheduler with a one-cycle behavioural stand-in for the sigmoid core.
module tb_sigmoid_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [63:0] rsp_y;
  logic        core_in_valid;
  logic [7:0]  core_x;
  logic [15:0] core_y;
  logic        core_out_valid;
  logic        busy;
  logic        err;

  logic        force_cov;
  logic        suppress;
  logic        cov_q;
  logic [15:0] cy_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sigmoid_rr_scheduler #(.NREQ(4), .LAT(1), .XW(8), .YW(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_x          (req_x),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_y          (rsp_y),
    .core_in_valid  (core_in_valid),
    .core_x         (core_x),
    .core_y         (core_y),
    .core_out_valid (core_out_valid),
    .busy           (busy),
    .err            (err)
  );

  // Core stand-in: 0x20 -> 0x1234, every operand gives a distinct result.
  function automatic logic [15:0] core_fn(input logic [7:0] x);
    return {x ^ 8'h32, x ^ 8'h14};
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cov_q <= 1'b0;
      cy_q  <= '0;
    end else begin
      cov_q <= core_in_valid;
      cy_q  <= core_fn(core_x);
    end
  end

  assign core_out_valid = (cov_q & ~suppress) | force_cov;
  assign core_y         = cy_q;

  function automatic logic [15:0] ry(input int k);
    return rsp_y[k*16 +: 16];
  endfunction

  function automatic logic [7:0] xk(input int k);
    return req_x[k*8 +: 8];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp4 [10] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3};

    // Reset held with every requester asking
    rst_n     = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'h0;
    req_x     = {8'h83, 8'h62, 8'h41, 8'h20};
    force_cov = 1'b0;
    suppress  = 1'b0;
    tick(3);
    chk("rst_req_ready", 64'(req_ready), 64'(4'h0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(4'h0));
    chk("rst_rsp_y", rsp_y, 64'h0);
    chk("rst_core_in_valid", 64'(core_in_valid), 64'(1'b0));
    chk("rst_core_x", 64'(core_x), 64'(8'h00));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_err", 64'(err), 64'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("first_grant", 64'(req_ready), 64'(4'b0001));
    chk("first_core_x", 64'(core_x), 64'(8'h20));

    // Single op on requester 0, result held until taken
    rst_n = 1'b1;
    tick(1);
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("single_t_ready", 64'(req_ready), 64'(4'b0001));
    chk("single_t_civ", 64'(core_in_valid), 64'(1'b1));
    chk("single_t_core_x", 64'(core_x), 64'(8'h20));
    tick(1);
    chk("single_t1_ready", 64'(req_ready), 64'(4'b0000));
    chk("single_t1_busy", 64'(busy), 64'(1'b1));
    chk("single_t1_rsp_valid", 64'(rsp_valid), 64'(4'b0000));
    tick(1);
    chk("single_t2_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    chk("single_t2_rsp_y", 64'(ry(0)), 64'(16'h1234));
    chk("single_t2_ready", 64'(req_ready), 64'(4'b0000));
    tick(2);
    chk("single_hold_valid", 64'(rsp_valid), 64'(4'b0001));
    chk("single_hold_y", 64'(ry(0)), 64'(16'h1234));
    rsp_ready = 4'b0001;
    #1;
    chk("single_ready_indep", 64'(req_ready), 64'(4'b0000));
    tick(1);
    chk("single_taken_valid", 64'(rsp_valid), 64'(4'b0000));
    chk("single_taken_busy", 64'(busy), 64'(1'b0));
    chk("single_regrant", 64'(req_ready), 64'(4'b0001));

    // All requesters with open sinks: full-rate rotation
    rst_n     = 1'b1;
    req_valid = 4'h0;
    rsp_ready = 4'h0;
    tick(1);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("rot_grant_c%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
      chk($sformatf("rot_civ_c%0d", c), 64'(core_in_valid), 64'(1'b1));
      if (c >= 2) begin
        chk($sformatf("rot_rsp_valid_c%0d", c), 64'(rsp_valid), 64'(4'b0001 << ((c - 2) % 4)));
        chk($sformatf("rot_rsp_y_c%0d", c), 64'(ry((c - 2) % 4)), 64'(core_fn(xk((c - 2) % 4))));
      end else begin
        chk($sformatf("rot_rsp_idle_c%0d", c), 64'(rsp_valid), 64'(4'b0000));
      end
      tick(1);
    end

    // Requester 1 stalls on its response
    rst_n     = 1'b1;
    req_valid = 4'h0;
    rsp_ready = 4'h0;
    tick(1);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'b1101;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_grant_c%0d", c), 64'(req_ready), 64'(4'b0001 << exp4[c]));
      if (c >= 3) begin
        chk($sformatf("bp_hold1_c%0d", c), 64'(rsp_valid[1]), 64'(1'b1));
        chk($sformatf("bp_y1_c%0d", c), 64'(ry(1)), 64'(core_fn(8'h41)));
      end
      tick(1);
    end
    rsp_ready = 4'hF;
    #1;
    chk("bp_release_grant0", 64'(req_ready), 64'(4'b0001));
    tick(1);
    chk("bp_release_grant1", 64'(req_ready), 64'(4'b0010));
    chk("bp_release_valid1", 64'(rsp_valid[1]), 64'(1'b0));

    // Reset while requester 2's op is in flight
    rst_n     = 1'b1;
    req_valid = 4'h0;
    tick(1);
    rst_n     = 1'b0;
    req_valid = 4'b0100;
    rsp_ready = 4'hF;
    #1;
    chk("midrst_grant2", 64'(req_ready), 64'(4'b0100));
    tick(1);
    rst_n     = 1'b1;
    req_valid = 4'h0;
    tick(1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(4'h0));
    chk("midrst_busy", 64'(busy), 64'(1'b0));
    chk("midrst_err", 64'(err), 64'(1'b0));
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      chk($sformatf("midrst_no_result_c%0d", c), 64'(rsp_valid), 64'(4'h0));
    end

    // Spurious core result with an empty tag pipe
    chk("err_before", 64'(err), 64'(1'b0));
    force_cov = 1'b1;
    tick(1);
    force_cov = 1'b0;
    chk("err_set", 64'(err), 64'(1'b1));
    chk("err_no_rsp", 64'(rsp_valid), 64'(4'h0));
    tick(2);
    chk("err_sticky", 64'(err), 64'(1'b1));
    rst_n = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("err_cleared", 64'(err), 64'(1'b0));

    // Tag reaches the head but the core stays silent
    req_valid = 4'b0001;
    suppress  = 1'b1;
    #1;
    chk("drop_grant", 64'(req_ready), 64'(4'b0001));
    tick(1);
    req_valid = 4'h0;
    #1;
    chk("drop_err_pre", 64'(err), 64'(1'b0));
    tick(1);
    chk("drop_err", 64'(err), 64'(1'b1));
    chk("drop_busy", 64'(busy), 64'(1'b0));
    chk("drop_rsp_valid", 64'(rsp_valid), 64'(4'h0));
    req_valid = 4'b0001;
    #1;
    chk("drop_regrant", 64'(req_ready), 64'(4'b0001));
    suppress = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
